// File: rtl/axi4lite_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi4lite_cmd_pkg
// Description : Shared types and constants for the AXI4-Lite command master.
// Revision    : 1.0
// ============================================================================
package axi4lite_cmd_pkg;

    localparam int AXI4LITE_CMD_MAX_ADDRESS_WIDTH = 32;
    localparam int AXI4LITE_CMD_DATA_WIDTH        = 32;

    localparam logic [1:0] AXI4LITE_OKAY   = 2'b00;
    localparam logic [1:0] AXI4LITE_SLVERR = 2'b10;
    localparam logic [1:0] AXI4LITE_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WRITE      = 3'd1,
        ST_WRITE_RESP = 3'd2,
        ST_READ_ADDR  = 3'd3,
        ST_READ_DATA  = 3'd4,
        ST_RESPONSE   = 3'd5
    } axi4lite_cmd_state_e;

    // Address is held at the widest supported size; the master drives only the low bits.
    typedef struct packed {
        logic                                      write;
        logic [AXI4LITE_CMD_MAX_ADDRESS_WIDTH-1:0] address;
        logic [AXI4LITE_CMD_DATA_WIDTH-1:0]        write_data;
        logic [AXI4LITE_CMD_DATA_WIDTH/8-1:0]      strobe;
    } axi4lite_cmd_t;

endpackage
`default_nettype wire

// File: rtl/rggen_axi4lite_if.sv
`default_nettype none
// ============================================================================
// Module      : rggen_axi4lite_if
// Description : AXI4-Lite bundle shared by the command master and register blocks.
// Revision    : 1.0
// ============================================================================
interface rggen_axi4lite_if #(
    parameter int ID_WIDTH      = 0,
    parameter int ADDRESS_WIDTH = 16,
    parameter int BUS_WIDTH     = 32
);
    localparam int C_ID_W = (ID_WIDTH > 0) ? ID_WIDTH : 1;

    logic                     awvalid;
    logic                     awready;
    logic [C_ID_W-1:0]        awid;
    logic [ADDRESS_WIDTH-1:0] awaddr;
    logic [2:0]               awprot;
    logic                     wvalid;
    logic                     wready;
    logic [BUS_WIDTH-1:0]     wdata;
    logic [BUS_WIDTH/8-1:0]   wstrb;
    logic                     bvalid;
    logic                     bready;
    logic [C_ID_W-1:0]        bid;
    logic [1:0]               bresp;
    logic                     arvalid;
    logic                     arready;
    logic [C_ID_W-1:0]        arid;
    logic [ADDRESS_WIDTH-1:0] araddr;
    logic [2:0]               arprot;
    logic                     rvalid;
    logic                     rready;
    logic [C_ID_W-1:0]        rid;
    logic [BUS_WIDTH-1:0]     rdata;
    logic [1:0]               rresp;

    modport master (
        output awvalid, awid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        output arvalid, arid, araddr, arprot, rready,
        input  awready, wready, bvalid, bid, bresp, arready, rvalid, rid, rdata, rresp
    );

    modport slave (
        input  awvalid, awid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        input  arvalid, arid, araddr, arprot, rready,
        output awready, wready, bvalid, bid, bresp, arready, rvalid, rid, rdata, rresp
    );
endinterface
`default_nettype wire

// File: rtl/axi4lite_cmd_master.sv
`default_nettype none
// ============================================================================
// Module      : axi4lite_cmd_master
// Description : Single-outstanding command/response port to AXI4-Lite master.
// Revision    : 1.0
// ============================================================================
module axi4lite_cmd_master
    import axi4lite_cmd_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = 5,
    parameter int BUS_WIDTH      = 32,
    parameter int ID_WIDTH       = 0,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_cmd_valid,
    output logic                     o_cmd_ready,
    input  logic                     i_cmd_write,
    input  logic [ADDRESS_WIDTH-1:0] i_cmd_address,
    input  logic [BUS_WIDTH-1:0]     i_cmd_write_data,
    input  logic [BUS_WIDTH/8-1:0]   i_cmd_strobe,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic [BUS_WIDTH-1:0]     o_rsp_read_data,
    output logic [1:0]               o_rsp_status,
    output logic                     o_rsp_timeout,
    output logic                     o_busy,
    rggen_axi4lite_if.master         axi4lite_if
);

    localparam int C_CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [C_CNT_W-1:0] C_TIMEOUT = C_CNT_W'(TIMEOUT_CYCLES);

    axi4lite_cmd_state_e  r_state;
    axi4lite_cmd_state_e  w_state_next;
    axi4lite_cmd_t        r_cmd;
    logic                 r_awvalid;
    logic                 r_wvalid;
    logic                 r_arvalid;
    logic [BUS_WIDTH-1:0] r_rsp_read_data;
    logic [1:0]           r_rsp_status;
    logic                 r_rsp_timeout;
    logic [C_CNT_W-1:0]   r_count;

    logic w_cmd_accept;
    logic w_active;
    logic w_expired;
    logic w_abort;
    logic w_b_hs;
    logic w_r_hs;
    logic w_unused_bits;

    assign w_cmd_accept = i_cmd_valid && (r_state == ST_IDLE);
    assign w_active     = (r_state == ST_WRITE) || (r_state == ST_WRITE_RESP) ||
                          (r_state == ST_READ_ADDR) || (r_state == ST_READ_DATA);
    assign w_expired    = (TIMEOUT_CYCLES != 0) && (r_count == C_TIMEOUT) && w_active;
    assign w_b_hs       = (r_state == ST_WRITE_RESP) && axi4lite_if.bvalid;
    assign w_r_hs       = (r_state == ST_READ_DATA) && axi4lite_if.rvalid;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Any handshake finishing this cycle takes priority over the watchdog.
    always_comb begin
        w_state_next = r_state;
        w_abort      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cmd_accept) begin
                    w_state_next = i_cmd_write ? ST_WRITE : ST_READ_ADDR;
                end
            end
            ST_WRITE: begin
                if ((!r_awvalid || axi4lite_if.awready) && (!r_wvalid || axi4lite_if.wready)) begin
                    w_state_next = ST_WRITE_RESP;
                end else if (w_expired) begin
                    w_state_next = ST_RESPONSE;
                    w_abort      = 1'b1;
                end
            end
            ST_WRITE_RESP: begin
                if (axi4lite_if.bvalid) begin
                    w_state_next = ST_RESPONSE;
                end else if (w_expired) begin
                    w_state_next = ST_RESPONSE;
                    w_abort      = 1'b1;
                end
            end
            ST_READ_ADDR: begin
                if (axi4lite_if.arready) begin
                    w_state_next = ST_READ_DATA;
                end else if (w_expired) begin
                    w_state_next = ST_RESPONSE;
                    w_abort      = 1'b1;
                end
            end
            ST_READ_DATA: begin
                if (axi4lite_if.rvalid) begin
                    w_state_next = ST_RESPONSE;
                end else if (w_expired) begin
                    w_state_next = ST_RESPONSE;
                    w_abort      = 1'b1;
                end
            end
            ST_RESPONSE: begin
                if (i_rsp_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cmd           <= '0;
            r_awvalid       <= 1'b0;
            r_wvalid        <= 1'b0;
            r_arvalid       <= 1'b0;
            r_rsp_read_data <= '0;
            r_rsp_status    <= AXI4LITE_OKAY;
            r_rsp_timeout   <= 1'b0;
            r_count         <= '0;
        end else if (w_cmd_accept) begin
            r_cmd.write      <= i_cmd_write;
            r_cmd.address    <= AXI4LITE_CMD_MAX_ADDRESS_WIDTH'(i_cmd_address);
            r_cmd.write_data <= i_cmd_write_data;
            r_cmd.strobe     <= i_cmd_strobe;
            r_awvalid        <= i_cmd_write;
            r_wvalid         <= i_cmd_write;
            r_arvalid        <= !i_cmd_write;
            r_count          <= '0;
        end else begin
            // Saturate so a late phase still sees the limit and aborts at once.
            if (w_active && (r_count != C_TIMEOUT)) begin
                r_count <= r_count + C_CNT_W'(1);
            end
            if (w_abort) begin
                r_awvalid       <= 1'b0;
                r_wvalid        <= 1'b0;
                r_arvalid       <= 1'b0;
                r_rsp_read_data <= '0;
                r_rsp_status    <= AXI4LITE_SLVERR;
                r_rsp_timeout   <= 1'b1;
            end else begin
                if (axi4lite_if.awready) begin
                    r_awvalid <= 1'b0;
                end
                if (axi4lite_if.wready) begin
                    r_wvalid <= 1'b0;
                end
                if (axi4lite_if.arready) begin
                    r_arvalid <= 1'b0;
                end
                if (w_b_hs) begin
                    r_rsp_read_data <= '0;
                    r_rsp_status    <= axi4lite_if.bresp;
                    r_rsp_timeout   <= 1'b0;
                end
                if (w_r_hs) begin
                    r_rsp_read_data <= axi4lite_if.rdata;
                    r_rsp_status    <= axi4lite_if.rresp;
                    r_rsp_timeout   <= 1'b0;
                end
            end
        end
    end

    assign axi4lite_if.awvalid = r_awvalid;
    assign axi4lite_if.awid    = '0;
    assign axi4lite_if.awaddr  = r_cmd.address[ADDRESS_WIDTH-1:0];
    assign axi4lite_if.awprot  = 3'b000;
    assign axi4lite_if.wvalid  = r_wvalid;
    assign axi4lite_if.wdata   = r_cmd.write_data;
    assign axi4lite_if.wstrb   = r_cmd.strobe;
    assign axi4lite_if.bready  = (r_state == ST_WRITE_RESP);
    assign axi4lite_if.arvalid = r_arvalid;
    assign axi4lite_if.arid    = '0;
    assign axi4lite_if.araddr  = r_cmd.address[ADDRESS_WIDTH-1:0];
    assign axi4lite_if.arprot  = 3'b000;
    assign axi4lite_if.rready  = (r_state == ST_READ_DATA);

    assign o_cmd_ready     = (r_state == ST_IDLE);
    assign o_busy          = (r_state != ST_IDLE);
    assign o_rsp_valid     = (r_state == ST_RESPONSE);
    assign o_rsp_read_data = r_rsp_read_data;
    assign o_rsp_status    = r_rsp_status;
    assign o_rsp_timeout   = r_rsp_timeout;

    assign w_unused_bits = ^{r_cmd.write, r_cmd.address, axi4lite_if.bid, axi4lite_if.rid};

endmodule
`default_nettype wire

// File: doc/axi4lite_cmd_master.md
Name: axi4lite_cmd_master

Overview:
- Upstream stage for the generated AXI4-Lite register blocks.
- Converts a simple single-outstanding command/response port (valid/ready) into AXI4-Lite master transactions on a rggen_axi4lite_if master modport.
- Used by the sequencer/debug path to program and read back register blocks.
- One transaction in flight at a time; optional watchdog timeout for dead slaves.

Parameters:
- ADDRESS_WIDTH, 5: AXI address width; must match downstream slave.
- BUS_WIDTH, 32: data width; only 32 is supported.
- ID_WIDTH, 0: interface ID width; all IDs are driven '0.
- TIMEOUT_CYCLES, 1024: watchdog limit in cycles per transaction; 0 disables the watchdog.

Ports:
- i_clk  input  1  clock
- i_rst_n  input  1  asynchronous active-low reset
- i_cmd_valid  input  1  command request
- o_cmd_ready  output  1  command accepted when high with i_cmd_valid
- i_cmd_write  input  1  1 = write, 0 = read
- i_cmd_address  input  ADDRESS_WIDTH  byte address
- i_cmd_write_data  input  BUS_WIDTH  write data
- i_cmd_strobe  input  BUS_WIDTH/8  byte strobes (ignored for reads)
- o_rsp_valid  output  1  response available
- i_rsp_ready  input  1  response consumed
- o_rsp_read_data  output  BUS_WIDTH  read data (0 for writes and timeouts)
- o_rsp_status  output  2  AXI resp code (00 OKAY, 10 SLVERR, 11 DECERR)
- o_rsp_timeout  output  1  watchdog expired
- o_busy  output  1  state != IDLE
- axi4lite_if  interface  master modport  AXI4-Lite master side

Behaviour:
- Clock and reset: single clock i_clk. Reset i_rst_n is asynchronous, active-low.
- Reset values: state IDLE; awvalid, wvalid, bready, arvalid, rready = 0; o_rsp_valid = 0; o_rsp_read_data = 0; o_rsp_status = 0; o_rsp_timeout = 0; counter = 0.
- Static drives: awprot/arprot = 3'b000; IDs = '0.
- States: IDLE, WRITE, WRITE_RESP, READ_ADDR, READ_DATA, RESPONSE.
- o_cmd_ready = (state == IDLE), combinational.
- On command handshake, register address, data and strobe. Next cycle:
  - Write: enter WRITE with awvalid = wvalid = 1.
  - Read: enter READ_ADDR with arvalid = 1.
- WRITE:
  - awvalid clears on awready; wvalid clears on wready. The two are independent and either order is allowed.
  - When both handshakes are done (including same cycle), go to WRITE_RESP.
  - awaddr, wdata and wstrb stay stable while their valid is high.
- WRITE_RESP: bready = 1. On bvalid, capture bresp into o_rsp_status and go to RESPONSE.
- READ_ADDR: arvalid held until arready, then go to READ_DATA.
- READ_DATA: rready = 1. On rvalid, capture rdata and rresp and go to RESPONSE.
- RESPONSE:
  - o_rsp_valid = 1; all response outputs are held stable until i_rsp_ready.
  - Then return to IDLE. The next command is accepted the cycle after the response handshake.
- Minimum latency, command accept to o_rsp_valid, with a zero-wait slave: write 3 cycles, read 3 cycles.
- Watchdog:
  - Counter clears on command accept and increments each cycle in WRITE, WRITE_RESP, READ_ADDR and READ_DATA.
  - When counter == TIMEOUT_CYCLES (and TIMEOUT_CYCLES != 0): drop all valids and readies, set o_rsp_timeout = 1, o_rsp_status = 2'b10, o_rsp_read_data = 0, and go to RESPONSE.
  - This abort deliberately breaks AXI valid stability. Protocol-clean builds use TIMEOUT_CYCLES = 0.
- Handshake completing in the same cycle as the timeout: the handshake wins and the timeout is not flagged.
- Reset mid-transaction: immediate return to reset values. The in-flight command is dropped and no response is produced.
- Write with strobe = 0: still issued on the bus.

Decomposition:
- Shared package axi4lite_cmd_pkg contains:
  - state enum axi4lite_cmd_state_e;
  - resp localparams AXI4LITE_OKAY / SLVERR / DECERR;
  - struct axi4lite_cmd_t {write, address, write_data, strobe} used for the command register.
- Single module with the watchdog counter inline; no sub-module needed.

Test Plan:
- Write 0x000001FF to 0x00, strobe 0xF, into a register block; then read 0x00 -> status 00, timeout 0, read data 0x000001FF.
- Write 0xFFFFFFFF to 0x00, then read 0x00 -> read data 0x000001FF (unused bits read as 0). Write 0xAABBCCDD to 0x04 with strobe 0x3 after 0x04 = 0, then read -> 0x0000CCDD.
- Stub slave: wready asserted 3 cycles before awready, bresp = 10 -> both valids clear on their own ready, response status 10.
- Stub slave: awready never asserted, TIMEOUT_CYCLES = 16 -> o_rsp_valid with timeout 1, status 10, data 0; o_busy falls after the response handshake.
- Hold i_rsp_ready low 5 cycles after a read of 0x1C containing 0x12345678 -> response outputs stable, o_cmd_ready 0; next command accepted the cycle after the handshake.
- Assert i_rst_n low during WRITE with awvalid = 1 -> all valids 0 immediately, o_rsp_valid stays 0, o_cmd_ready 1 after reset release.
